// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared states, opcodes and datapath select encodings for regfile_ctrl.
package regfile_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_REG
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

endpackage

// File: rtl/regfile_ctrl_instr_dec.sv
// regfile_ctrl_instr_dec: splits the instruction register into fields and sign-extends the immediates.
module regfile_ctrl_instr_dec #(
    parameter int DW  = 16,
    parameter int RNW = 3
) (
    input  logic [DW-1:0]  ir,
    output logic [2:0]     opcode,
    output logic [1:0]     op,
    output logic [RNW-1:0] rn,
    output logic [RNW-1:0] rd,
    output logic [RNW-1:0] rm,
    output logic [1:0]     sh,
    output logic [DW-1:0]  sximm8,
    output logic [DW-1:0]  sximm5
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(DW-5){ir[4]}}, ir[4:0]};

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: multicycle controller sequencing one instruction at a time through the register file datapath.
// Define REGFILE_CTRL_ILLEGAL_EN to add a sticky err output flagging unsupported instructions.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int DW  = 16,
    parameter int RNW = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s,
    input  logic [DW-1:0]  in,
    output logic           w,
    output logic [RNW-1:0] readnum,
    output logic [RNW-1:0] writenum,
    output logic           write,
    output logic           loada,
    output logic           loadb,
    output logic           loadc,
    output logic           loads,
    output logic           asel,
    output logic           bsel,
    output logic [1:0]     vsel,
    output logic [1:0]     shift,
    output logic [1:0]     ALUop,
`ifdef REGFILE_CTRL_ILLEGAL_EN
    output logic           err,
`endif
    output logic [DW-1:0]  sximm8,
    output logic [DW-1:0]  sximm5
);

    state_t state, next;
    logic [DW-1:0] ir;
    logic [2:0] opcode;
    logic [1:0] op, sh;
    logic [RNW-1:0] rn, rd, rm;
    logic is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp, legal;

    regfile_ctrl_instr_dec #(.DW(DW), .RNW(RNW)) u_dec (
        .ir(ir), .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm),
        .sh(sh), .sximm8(sximm8), .sximm5(sximm5)
    );

    assign is_mov_imm = opcode == OPC_MOV && op == MOV_IMM;
    assign is_mov_reg = opcode == OPC_MOV && op == MOV_REG;
    assign is_alu     = opcode == OPC_ALU;
    assign is_mvn     = is_alu && op == ALU_MVN;
    assign is_cmp     = is_alu && op == ALU_CMP;
    assign legal      = is_mov_imm || is_mov_reg || is_alu;

    always_ff @(posedge clk) begin
        if (reset) state <= S_WAIT;
        else       state <= next;
    end

    always_ff @(posedge clk) begin
        if (reset)                      ir <= '0;
        else if (state == S_WAIT && s)  ir <= in;
    end

`ifdef REGFILE_CTRL_ILLEGAL_EN
    always_ff @(posedge clk) begin
        if (reset)                               err <= 1'b0;
        else if (state == S_DECODE && !legal)    err <= 1'b1;
    end
`endif

    // MOV-reg and MVN skip GET_A: their A operand is forced to zero in ALU
    always_comb begin
        next = S_WAIT;
        case (state)
            S_WAIT:   next = s ? S_DECODE : S_WAIT;
            S_DECODE: next = is_mov_imm ? S_WR_IMM :
                             (is_mov_reg || is_mvn) ? S_GET_B :
                             legal ? S_GET_A : S_WAIT;
            S_GET_A:  next = S_GET_B;
            S_GET_B:  next = S_ALU;
            S_ALU:    next = is_cmp ? S_WAIT : S_WR_REG;
            default:  next = S_WAIT;
        endcase
    end

    always_comb begin
        w        = state == S_WAIT;
        readnum  = state == S_GET_A ? rn : state == S_GET_B ? rm : '0;
        writenum = state == S_WR_IMM ? rn : state == S_WR_REG ? rd : '0;
        write    = state == S_WR_IMM || state == S_WR_REG;
        loada    = state == S_GET_A;
        loadb    = state == S_GET_B;
        loadc    = state == S_ALU && !is_cmp;
        loads    = state == S_ALU && is_cmp;
        asel     = state == S_ALU && (is_mov_reg || is_mvn);
        bsel     = 1'b0;
        vsel     = state == S_WR_IMM ? VSEL_IMM : VSEL_C;
        shift    = state == S_ALU ? sh : 2'b00;
        ALUop    = state == S_ALU ? op : 2'b00;
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed vectors for regfile_ctrl with hand-computed expectations.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        reset, s;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;
`ifdef REGFILE_CTRL_ILLEGAL_EN
    logic        err;
`endif
    logic [4:0]  stb;
    int          total = 0;
    int          passed = 0;

    assign stb = {write, loada, loadb, loadc, loads};

    always #5 clk = ~clk;

    regfile_ctrl dut (
        .clk(clk), .reset(reset), .s(s), .in(in), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
`ifdef REGFILE_CTRL_ILLEGAL_EN
        .err(err),
`endif
        .sximm8(sximm8), .sximm5(sximm5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // stb order: write, loada, loadb, loadc, loads
    initial begin
        reset = 1'b1; s = 1'b0; in = 16'h0000;
        step(); step();
        reset = 1'b0;
        chk("rst_w", w, 1); chk("rst_stb", stb, 5'b00000);
        chk("rst_rn", readnum, 0); chk("rst_wn", writenum, 0);
        chk("rst_vsel", vsel, 0); chk("rst_shift", shift, 0); chk("rst_aluop", ALUop, 0);
`ifdef REGFILE_CTRL_ILLEGAL_EN
        chk("rst_err", err, 0);
`endif
        step();
        chk("idle_w", w, 1); chk("idle_stb", stb, 5'b00000);

        // MOV R2,#7
        in = 16'hD207; s = 1'b1;
        step(); s = 1'b0;
        chk("mi_dec_w", w, 0); chk("mi_dec_stb", stb, 5'b00000);
        step();
        chk("mi_wr_stb", stb, 5'b10000); chk("mi_wr_wn", writenum, 2);
        chk("mi_wr_vsel", vsel, 2'b10); chk("mi_imm8", sximm8, 16'h0007);
        step();
        chk("mi_done_w", w, 1); chk("mi_done_stb", stb, 5'b00000);

        // MOV R1,#-1
        in = 16'hD1FF; s = 1'b1;
        step(); s = 1'b0;
        chk("mn_imm8", sximm8, 16'hFFFF); chk("mn_imm5", sximm5, 16'hFFFF);
        step();
        chk("mn_wr_stb", stb, 5'b10000); chk("mn_wr_wn", writenum, 1);
        step();
        chk("mn_done_w", w, 1);

        // ADD R5,R2,R1
        in = 16'hA2A1; s = 1'b1;
        step(); s = 1'b0;
        chk("add_dec_stb", stb, 5'b00000);
        step();
        chk("add_ga_stb", stb, 5'b01000); chk("add_ga_rn", readnum, 2);
        step();
        chk("add_gb_stb", stb, 5'b00100); chk("add_gb_rn", readnum, 1);
        step();
        chk("add_alu_stb", stb, 5'b00010); chk("add_alu_op", ALUop, 0);
        chk("add_alu_asel", asel, 0);
        step();
        chk("add_wr_stb", stb, 5'b10000); chk("add_wr_wn", writenum, 5);
        chk("add_wr_vsel", vsel, 0); chk("add_wr_w", w, 0);
        step();
        chk("add_done_w", w, 1);

        // CMP R2,R1
        in = 16'hAA01; s = 1'b1;
        step(); s = 1'b0;
        chk("cmp_dec_stb", stb, 5'b00000);
        step();
        chk("cmp_ga_stb", stb, 5'b01000); chk("cmp_ga_rn", readnum, 2);
        step();
        chk("cmp_gb_stb", stb, 5'b00100); chk("cmp_gb_rn", readnum, 1);
        step();
        chk("cmp_alu_stb", stb, 5'b00001); chk("cmp_alu_op", ALUop, 2'b01);
        chk("cmp_alu_w", w, 0);
        step();
        chk("cmp_done_w", w, 1); chk("cmp_done_stb", stb, 5'b00000);

        // MOV R6,R1,LSL#1 with s held high; changing in mid-op must not disturb IR
        in = 16'hC0C9; s = 1'b1;
        step();
        in = 16'hD305;
        chk("mr_dec_w", w, 0);
        step();
        chk("mr_gb_stb", stb, 5'b00100); chk("mr_gb_rn", readnum, 1);
        step();
        chk("mr_alu_stb", stb, 5'b00010); chk("mr_alu_asel", asel, 1);
        chk("mr_alu_shift", shift, 2'b01); chk("mr_alu_op", ALUop, 0);
        chk("mr_alu_bsel", bsel, 0);
        step();
        chk("mr_wr_stb", stb, 5'b10000); chk("mr_wr_wn", writenum, 6);
        step();
        chk("mr_wait_w", w, 1);
        step();
        chk("held_dec_w", w, 0); chk("held_dec_stb", stb, 5'b00000);
        s = 1'b0;
        step();
        chk("held_wr_stb", stb, 5'b10000); chk("held_wr_wn", writenum, 3);
        chk("held_imm8", sximm8, 16'h0005);
        step();
        chk("held_done_w", w, 1);

        // reset during GET_B of ADD
        in = 16'hA2A1; s = 1'b1;
        step(); s = 1'b0;
        step();
        step();
        chk("rm_gb_rn", readnum, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rm_w", w, 1); chk("rm_stb", stb, 5'b00000);
        chk("rm_ir_clr", sximm8, 16'h0000);
        step();
        chk("rm_idle_w", w, 1); chk("rm_idle_stb", stb, 5'b00000);

        // unsupported instruction
        in = 16'h0000; s = 1'b1;
        step(); s = 1'b0;
        chk("ill_dec_w", w, 0); chk("ill_dec_stb", stb, 5'b00000);
        step();
        chk("ill_done_w", w, 1); chk("ill_done_stb", stb, 5'b00000);
`ifdef REGFILE_CTRL_ILLEGAL_EN
        chk("ill_err", err, 1);
        step(); step();
        chk("ill_err_sticky", err, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("ill_err_clr", err, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
